sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words; it is a power of two and at least 2.
REQ-003 SHALL have parameter WAIT_STATES, default 1, meaning the extra cycles before the response; the legal range is 0..15.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port mem_valid, input, 1 bit: initiator request.
REQ-007 SHALL have port mem_addr, input, 32 bits: byte address; bits [1:0] are ignored.
REQ-008 SHALL have port mem_wstrb, input, 4 bits: byte-lane write enables; 4'b0000 means read.
REQ-009 SHALL have port mem_wdata, input, 32 bits: write data, already lane-aligned.
REQ-010 SHALL have port mem_ready, output, 1 bit: one-cycle response strobe.
REQ-011 SHALL have port mem_rdata, output, 32 bits: read data, valid while mem_ready=1.
REQ-012 SHALL have port mem_err, output, 1 bit: access outside the window, valid while mem_ready=1.

Function
REQ-013 The state machine SHALL have states IDLE, WAIT, RESP and TURN, all registered; mem_ready, mem_rdata and mem_err SHALL be register outputs.
REQ-014 An access SHALL be in range iff BASE_ADDR <= mem_addr < BASE_ADDR+4*DEPTH_WORDS, computed without 32-bit wrap-around.
- Word index = (mem_addr-BASE_ADDR)>>2.
REQ-015 IDLE with mem_valid=1 SHALL capture addr, wstrb, wdata and the in-range flag.
- Go to RESP if WAIT_STATES=0; otherwise go to WAIT with counter=WAIT_STATES-1.
REQ-016 IDLE with mem_valid=0 SHALL remain in IDLE.
REQ-017 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where counter=0.
- Result: mem_ready is high exactly in cycle N+1+WAIT_STATES, where N is the cycle in which IDLE sampled mem_valid=1.
REQ-018 On the edge entering RESP, an in-range write SHALL update only the byte lanes with wstrb[i]=1.
- Other lanes of that word keep their value.
- No other word changes.
REQ-019 On the edge entering RESP, an in-range read SHALL load mem_rdata with the addressed word.
REQ-020 On the edge entering RESP, a write SHALL leave mem_rdata unchanged.
REQ-021 On the edge entering RESP, an out-of-range access SHALL set mem_err=1 and mem_rdata=0.
- No storage is modified.
REQ-022 RESP SHALL last exactly one cycle with mem_ready=1, then go to TURN.
- mem_ready=0 and mem_err=0 in all other states.
REQ-023 TURN SHALL last one cycle, ignore mem_valid, and go to IDLE.
- This gives the initiator one cycle to drop mem_valid.
- Minimum spacing between the ready pulses of back-to-back requests is WAIT_STATES+3 cycles.
REQ-024 If mem_valid falls in WAIT (a protocol violation), the access SHALL be aborted.
- Go to IDLE next edge.
- No write and no mem_ready pulse.
REQ-025 mem_rdata SHALL hold its last value outside RESP.
REQ-026 Captured request fields SHALL be used, so changes on mem_addr, mem_wstrb and mem_wdata after capture have no effect.
REQ-027 Storage SHALL be an inferable single-port synchronous RAM of DEPTH_WORDS x 32 with no reset of its contents.

Reset
REQ-028 resetn=0 SHALL immediately (asynchronously) force state=IDLE, counter=0, mem_ready=0, mem_err=0 and mem_rdata=32'h0000_0000.
REQ-029 Reset asserted during WAIT or RESP SHALL cancel the access.
- A write whose RESP-entry edge has not occurred is not committed.
- RAM contents are otherwise preserved.
REQ-030 The first request SHALL be sampled in the first cycle with resetn=1.

Verification
REQ-031 Scenario 1 (W=1): write 32'hDEAD_BEEF, wstrb=4'hF, to 32'h8000_0010, then read it back.
- Required: mem_ready in cycle N+2, mem_err=0, rdata 32'hDEAD_BEEF.
REQ-032 Scenario 2: word holds 32'h1122_3344; write 32'hAA00_00BB with wstrb=4'b1001.
- Required: read returns 32'hAA22_33BB.
REQ-033 Scenario 3: read 32'h7FFF_FFFC and read 32'h8000_1000, both out of range.
- Required: each gives mem_ready with mem_err=1 and rdata=0.
- Required: a subsequent read of 32'h8000_0000 is unchanged.
REQ-034 Scenario 4 (W=0): mem_valid held high continuously across two requests.
- Required: ready pulses in cycles N+1 and N+4, and the TURN cycle is ignored.
REQ-035 Scenario 5 (W=3): a write is issued, and resetn is pulsed low during WAIT.
- Required: no mem_ready, all outputs 0.
- Required: a later read returns the old data.
REQ-036 Scenario 6 (W=2): mem_valid drops in the first WAIT cycle.
- Required: no ready pulse, and IDLE on the next edge.
- Required: a new request is accepted in the following cycle.

Source files
------------

// File: rtl/sram_responder.sv
// rtl/sram_responder.sv - wait-stated single-port SRAM responder with window decode
module sram_responder #(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_wdata,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        mem_err
);

    localparam int          AW       = $clog2(DEPTH_WORDS);
    localparam logic [32:0] LIMIT    = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) << 2);
    localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_TURN} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [3:0]        cnt;
    logic [AW-1:0]     cap_idx;
    logic [3:0]        cap_wstrb;
    logic [31:0]       cap_wdata;
    logic              cap_in_range;

    logic              live_in_range;
    logic [AW-1:0]     live_idx;
    logic [AW-1:0]     acc_idx;
    logic [3:0]        acc_wstrb;
    logic [31:0]       acc_wdata;
    logic              acc_in_range;
    logic              enter_resp;
    logic              ram_we;
    logic              rd_load;

    logic [31:0]       ram [DEPTH_WORDS];

    // Window decode on the live bus, done in 33 bits so the top of the map cannot wrap
    always_comb begin
        live_in_range = ({1'b0, mem_addr} >= {1'b0, BASE_ADDR}) && ({1'b0, mem_addr} < LIMIT);
        live_idx      = AW'((mem_addr - BASE_ADDR) >> 2);
    end

    // State register
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Next-state logic; dropping mem_valid while waiting aborts the access
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: if (mem_valid) state_nxt = (WAIT_STATES == 0) ? S_RESP : S_WAIT;
            S_WAIT: begin
                if (!mem_valid)     state_nxt = S_IDLE;
                else if (cnt == 0)  state_nxt = S_RESP;
            end
            S_RESP: state_nxt = S_TURN;
            S_TURN: state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Access decisions; with zero wait states the live bus is used on the capture edge itself
    always_comb begin
        acc_idx      = (state == S_IDLE) ? live_idx      : cap_idx;
        acc_wstrb    = (state == S_IDLE) ? mem_wstrb     : cap_wstrb;
        acc_wdata    = (state == S_IDLE) ? mem_wdata     : cap_wdata;
        acc_in_range = (state == S_IDLE) ? live_in_range : cap_in_range;
        enter_resp   = resetn && (state_nxt == S_RESP);
        ram_we       = enter_resp && acc_in_range && (acc_wstrb != 4'b0000);
        rd_load      = enter_resp && acc_in_range && (acc_wstrb == 4'b0000);
    end

    // Request capture and wait counter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= 4'd0;
            cap_idx      <= '0;
            cap_wstrb    <= 4'd0;
            cap_wdata    <= 32'd0;
            cap_in_range <= 1'b0;
        end else if (state == S_IDLE && mem_valid) begin
            cnt          <= CNT_INIT;
            cap_idx      <= live_idx;
            cap_wstrb    <= mem_wstrb;
            cap_wdata    <= mem_wdata;
            cap_in_range <= live_in_range;
        end else if (state == S_WAIT) begin
            cnt          <= cnt - 4'd1;
        end
    end

    // Registered response outputs, loaded on the edge entering RESP
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            mem_rdata <= 32'h0000_0000;
        end else begin
            mem_ready <= enter_resp;
            mem_err   <= enter_resp && !acc_in_range;
            if (enter_resp && !acc_in_range) mem_rdata <= 32'h0000_0000;
            else if (rd_load)                mem_rdata <= ram[acc_idx];
        end
    end

    // Byte-lane writes into the storage array; contents are never reset
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_wstrb[i]) ram[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_sram_responder.sv
// tb/tb_sram_responder.sv - directed bench over four wait-state configurations
module tb_sram_responder;

    localparam logic [31:0] B = 32'h8000_0000;

    logic        clk;
    logic        rstn   [4];
    logic        valid  [4];
    logic [31:0] addr   [4];
    logic [3:0]  wstrb  [4];
    logic [31:0] wdata  [4];
    logic        ready  [4];
    logic [31:0] rdata  [4];
    logic        err    [4];

    int n_checks = 0;
    int n_pass   = 0;

    // instance 0: W=1, 1: W=0, 2: W=3, 3: W=2
    for (genvar g = 0; g < 4; g++) begin : g_dut
        sram_responder #(
            .WAIT_STATES((g == 0) ? 1 : (g == 1) ? 0 : (g == 2) ? 3 : 2)
        ) u_dut (
            .clk       (clk),
            .resetn    (rstn[g]),
            .mem_valid (valid[g]),
            .mem_addr  (addr[g]),
            .mem_wstrb (wstrb[g]),
            .mem_wdata (wdata[g]),
            .mem_ready (ready[g]),
            .mem_rdata (rdata[g]),
            .mem_err   (err[g])
        );
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One request; fields are scrambled after capture to show they are latched
    task automatic access(input int i, input logic [31:0] a, input logic [3:0] s,
                          input logic [31:0] d, output logic [31:0] rd,
                          output logic e, output int lat);
        addr[i] = a; wstrb[i] = s; wdata[i] = d; valid[i] = 1'b1;
        lat = 0; rd = 32'h0; e = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (ready[i]) begin
                lat = k; rd = rdata[i]; e = err[i];
                break;
            end
            addr[i] = ~a; wdata[i] = ~d; wstrb[i] = ~s;
        end
        valid[i] = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [31:0] rd, rd1, rd2;
    logic        e;
    int          lat;
    logic [31:0] mask;

    initial begin
        for (int i = 0; i < 4; i++) begin
            rstn[i] = 1'b0; valid[i] = 1'b0; addr[i] = 32'h0; wstrb[i] = 4'h0; wdata[i] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        check("rst ready", 32'(ready[0]), 32'd0);
        check("rst err",   32'(err[0]),   32'd0);
        check("rst rdata", rdata[0],      32'h0);
        for (int i = 0; i < 4; i++) rstn[i] = 1'b1;

        // Scenario 1, W=1
        access(0, B + 32'h10, 4'hF, 32'hDEAD_BEEF, rd, e, lat);
        check("s1 wr lat",   32'(lat), 32'd2);
        check("s1 wr err",   32'(e),   32'd0);
        check("s1 wr rdata", rd,       32'h0);
        access(0, B + 32'h10, 4'h0, 32'h0, rd, e, lat);
        check("s1 rd lat",   32'(lat), 32'd2);
        check("s1 rd err",   32'(e),   32'd0);
        check("s1 rd data",  rd,       32'hDEAD_BEEF);
        check("s1 hold",     rdata[0], 32'hDEAD_BEEF);

        // Scenario 2, partial write
        access(0, B + 32'h20, 4'hF, 32'h1122_3344, rd, e, lat);
        access(0, B + 32'h20, 4'b1001, 32'hAA00_00BB, rd, e, lat);
        access(0, B + 32'h20, 4'h0, 32'h0, rd, e, lat);
        check("s2 merge",    rd, 32'hAA22_33BB);
        access(0, B + 32'h10, 4'h0, 32'h0, rd, e, lat);
        check("s2 neighbor", rd, 32'hDEAD_BEEF);

        // Scenario 3, window edges
        access(0, B, 4'hF, 32'h0BAD_F00D, rd, e, lat);
        access(0, 32'h7FFF_FFFC, 4'h0, 32'h0, rd, e, lat);
        check("s3 lo err",   32'(e),   32'd1);
        check("s3 lo rdata", rd,       32'h0);
        check("s3 lo lat",   32'(lat), 32'd2);
        access(0, 32'h8000_1000, 4'h0, 32'h0, rd, e, lat);
        check("s3 hi err",   32'(e), 32'd1);
        check("s3 hi rdata", rd,     32'h0);
        access(0, 32'h8000_1000, 4'hF, 32'h5555_5555, rd, e, lat);
        check("s3 hi wr err", 32'(e), 32'd1);
        access(0, B, 4'h0, 32'h0, rd, e, lat);
        check("s3 word0",    rd,     32'h0BAD_F00D);
        check("s3 word0 err", 32'(e), 32'd0);
        access(0, 32'h8000_0FFF, 4'hF, 32'h600D_CAFE, rd, e, lat);
        access(0, 32'h8000_0FFC, 4'h0, 32'h0, rd, e, lat);
        check("s3 top err",  32'(e), 32'd0);
        check("s3 top data", rd,     32'h600D_CAFE);

        // Scenario 4, W=0, valid held across two requests
        access(1, B + 32'h8, 4'hF, 32'h1234_5678, rd, e, lat);
        check("s4 lat", 32'(lat), 32'd1);
        access(1, B + 32'hC, 4'hF, 32'h8765_4321, rd, e, lat);
        addr[1] = B + 32'h8; wstrb[1] = 4'h0; valid[1] = 1'b1;
        mask = 32'h0; rd1 = 32'h0; rd2 = 32'h0;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (ready[1]) begin
                mask[k-1] = 1'b1;
                if (k == 1) rd1 = rdata[1];
                if (k == 4) rd2 = rdata[1];
            end
            if (k == 1) addr[1] = B + 32'hC;
            if (k == 4) valid[1] = 1'b0;
        end
        check("s4 pulses", mask, 32'b001001);
        check("s4 rd1",    rd1,  32'h1234_5678);
        check("s4 rd2",    rd2,  32'h8765_4321);

        // Scenario 5, W=3, reset during WAIT
        access(2, B + 32'h4, 4'hF, 32'hCAFE_F00D, rd, e, lat);
        check("s5 lat", 32'(lat), 32'd4);
        access(2, B + 32'h4, 4'h0, 32'h0, rd, e, lat);
        check("s5 pre rd", rd, 32'hCAFE_F00D);
        addr[2] = B + 32'h4; wstrb[2] = 4'hF; wdata[2] = 32'h0; valid[2] = 1'b1;
        mask = 32'h0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            if (ready[2]) mask[0] = 1'b1;
        end
        rstn[2] = 1'b0;
        #1;
        check("s5 rst ready", 32'(ready[2]), 32'd0);
        check("s5 rst err",   32'(err[2]),   32'd0);
        check("s5 rst rdata", rdata[2],      32'h0);
        @(posedge clk); #1;
        valid[2] = 1'b0; rstn[2] = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            if (ready[2]) mask[0] = 1'b1;
        end
        check("s5 no ready", mask, 32'h0);
        access(2, B + 32'h4, 4'h0, 32'h0, rd, e, lat);
        check("s5 old data", rd, 32'hCAFE_F00D);

        // Scenario 6, W=2, valid drops in WAIT
        access(3, B + 32'h40, 4'hF, 32'h1111_2222, rd, e, lat);
        check("s6 lat", 32'(lat), 32'd3);
        addr[3] = B + 32'h40; wstrb[3] = 4'hF; wdata[3] = 32'h9999_9999; valid[3] = 1'b1;
        mask = 32'h0;
        @(posedge clk); #1;
        valid[3] = 1'b0;
        @(posedge clk); #1;
        if (ready[3]) mask[0] = 1'b1;
        access(3, B + 32'h40, 4'h0, 32'h0, rd, e, lat);
        check("s6 no ready", mask,     32'h0);
        check("s6 new lat",  32'(lat), 32'd3);
        check("s6 data",     rd,       32'h1111_2222);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
